im_loader: RTL

- Boot-time writer for the instruction memory (IM).
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles the bytes into little-endian 32-bit instruction words and drives the IM write port at consecutive word-aligned byte addresses starting at 0.
- The fetch path later reads the same image through the IM read port (16-bit byte address in, 32-bit instruction out).

---
 rtl/im_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Boot-time instruction memory loader: turns a byte stream (16-bit word count
// followed by little-endian words) into consecutive word writes from address 0.
module im_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    logic [15:0]      r_count;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_lane;
    logic [31:0]      r_buf;

    logic             w_xfer;
    logic [15:0]      w_n_full;
    logic [IDX_W-1:0] w_idx_next;

    assign w_xfer     = in_valid & in_ready;
    assign w_n_full   = {in_data, r_count[7:0]};
    assign w_idx_next = r_idx + IDX_W'(1);

    // Outputs are registered alongside the state they belong to, so every
    // transition sets them for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_idx    <= '0;
            r_lane   <= '0;
            r_buf    <= '0;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wd    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state  <= S_HDR0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (w_xfer) begin
                        r_count[7:0] <= in_data;
                        r_state      <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_count[15:8] <= in_data;
                        if (w_n_full > 16'(MAX_WORDS)) begin
                            r_state  <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else if (w_n_full == 16'd0) begin
                            r_state  <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                            r_lane  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_buf[{r_lane, 3'b000} +: 8] <= in_data;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_state  <= S_WRITE;
                            in_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_addr  <= ADDR_W'({r_idx, 2'b00});
                            im_wd    <= {in_data, r_buf[23:0]};
                        end
                    end
                end
                S_WRITE: begin
                    r_idx <= w_idx_next;
                    if (16'(w_idx_next) == r_count) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state  <= S_DATA;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
